control_unit: RTL and testbench

- Hardwired state-machine control unit for the 32-bit ARM-style CPU datapath.
- Decodes `ir`, sequences fetch, decode and execute.
- Drives register-file, IR, MAR, MDR and flag-register load strobes, memory handshake signals, datapath mux selects and the ALU opcode.
- Exposes its current state number on `S5..S0`.

---
 rtl/control_unit.sv | 150 +++++++++++++++
 tb/tb_control_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// control_unit: hardwired fetch/decode/execute FSM for the ARM-style datapath (optional MOC_TIMEOUT_EN aborts stalled memory waits)
module control_unit
`ifdef MOC_TIMEOUT_EN
  #(parameter int MOC_TIMEOUT = 16)
`endif
(
  input  logic        CLK,
  input  logic        CLR,
  input  logic        MOC,
  input  logic [31:0] ir,
  output logic        RFLd,
  output logic        IRLd,
  output logic        MARLd,
  output logic        MDRLd,
  output logic        FRLd,
  output logic        RW,
  output logic        MOV,
  output logic        typeData,
  output logic [3:0]  px,
  output logic [1:0]  MA,
  output logic [1:0]  MB,
  output logic [2:0]  MC,
  output logic        MD,
  output logic        ME,
  output logic [1:0]  MF,
  output logic        MG,
  output logic        MH,
  output logic [1:0]  MI,
  output logic [1:0]  MJ,
  output logic        E,
  output logic [2:0]  T,
  output logic [5:0]  S,
  output logic [4:0]  OP
);
  typedef enum logic [5:0] {
    RESET    = 6'd0,
    FETCH1   = 6'd1,
    FETCH2   = 6'd2,
    FETCH3   = 6'd3,
    DECODE   = 6'd4,
    DP_REG   = 6'd5,
    DP_IMM   = 6'd6,
    ADDR     = 6'd7,
    LD_READ  = 6'd8,
    LD_WB    = 6'd9,
    ST_MDR   = 6'd10,
    ST_WRITE = 6'd11,
    BASE_WB  = 6'd12,
    BL_LINK  = 6'd13,
    BRANCH   = 6'd14
  } state_t;
  state_t state, next;
  logic wb, tst, abort;
  logic [1:0] mb_addr, mf_addr;
  logic [2:0] t_addr;
  logic [4:0] op_arith;
  logic unused;
  assign unused = &{1'b0, ir[31:28], ir[11:7], ir[3:0]};
  assign wb = ir[21] | ~ir[24];
  assign tst = ir[24:23] == 2'b10;
  assign mb_addr = ir[25] ? 2'b00 : 2'b01;
  assign mf_addr = ir[25] ? 2'b01 : 2'b00;
  assign t_addr = ir[25] ? {1'b0, ir[6:5]} : 3'b100;
  assign op_arith = ir[23] ? 5'b10001 : 5'b10010;
  assign S = state;
  assign px = MC == 3'b001 ? 4'd15 : MC == 3'b010 ? 4'd14 : MC == 3'b011 ? ir[19:16] : ir[15:12];
`ifdef MOC_TIMEOUT_EN
  logic stall;
  logic [$clog2(MOC_TIMEOUT+1)-1:0] cnt;
  assign stall = (state == FETCH3 || state == LD_READ || state == ST_WRITE) && !MOC;
  assign abort = stall && cnt == ($bits(cnt))'(MOC_TIMEOUT - 1);
  // count consecutive MOC-low cycles spent in the current wait state
  always_ff @(posedge CLK)
    if (CLR || next != state) cnt <= '0;
    else if (stall) cnt <= cnt + 1'b1;
`else
  assign abort = 1'b0;
`endif
  // state register
  always_ff @(posedge CLK)
    state <= CLR ? RESET : next;
  // next-state and Moore outputs
  always_comb begin
    next = FETCH1;
    RFLd = 1'b0; IRLd = 1'b0; MARLd = 1'b0; MDRLd = 1'b0; FRLd = 1'b0;
    RW = 1'b1; MOV = 1'b0; typeData = 1'b0;
    MA = 2'b00; MB = 2'b00; MC = 3'b000; MD = 1'b0; ME = 1'b0; MF = 2'b00;
    MG = 1'b0; MH = 1'b0; MI = 2'b00; MJ = 2'b00; E = 1'b0;
    T = 3'b100; OP = 5'b10000;
    case (state)
      RESET: next = FETCH1;
      FETCH1: begin
        ME = 1'b1; MARLd = 1'b1; next = FETCH2;
      end
      FETCH2: begin
        MA = 2'b01; MB = 2'b11; OP = 5'b10001; MC = 3'b001; RFLd = 1'b1; MOV = 1'b1;
        next = FETCH3;
      end
      FETCH3: begin
        MOV = ~abort; IRLd = MOC;
        next = MOC ? DECODE : abort ? FETCH1 : FETCH3;
      end
      DECODE: begin
        E = 1'b1;
        next = ir[27:25] == 3'b000 ? DP_REG :
               ir[27:25] == 3'b001 ? DP_IMM :
               ir[27:26] == 2'b01  ? ADDR :
               ir[27:25] == 3'b101 ? (ir[24] ? BL_LINK : BRANCH) : FETCH1;
      end
      DP_REG: begin
        RFLd = ~tst; FRLd = ir[20] | tst; MF = ir[4] ? 2'b10 : 2'b01;
        T = {1'b0, ir[6:5]}; OP = {1'b0, ir[24:21]};
      end
      DP_IMM: begin
        RFLd = ~tst; FRLd = ir[20] | tst; MB = 2'b01; MJ = 2'b01; MF = 2'b11;
        OP = {1'b0, ir[24:21]};
      end
      ADDR: begin
        MB = mb_addr; MF = mf_addr; T = t_addr; MARLd = 1'b1;
        OP = ir[24] ? op_arith : 5'b10000;
        next = ir[20] ? LD_READ : ST_MDR;
      end
      LD_READ: begin
        MOV = ~abort; MDRLd = MOC; typeData = ir[22];
        next = MOC ? LD_WB : abort ? FETCH1 : LD_READ;
      end
      LD_WB: begin
        MA = 2'b10; MD = 1'b1; RFLd = 1'b1;
        next = wb ? BASE_WB : FETCH1;
      end
      ST_MDR: begin
        MH = 1'b1; MG = 1'b1; MDRLd = 1'b1; next = ST_WRITE;
      end
      ST_WRITE: begin
        MOV = ~abort; RW = 1'b0; typeData = ir[22];
        next = MOC ? (wb ? BASE_WB : FETCH1) : abort ? FETCH1 : ST_WRITE;
      end
      BASE_WB: begin
        MC = 3'b011; RFLd = 1'b1; MB = mb_addr; MF = mf_addr; T = t_addr; OP = op_arith;
      end
      BL_LINK: begin
        MI = 2'b01; MC = 3'b010; RFLd = 1'b1; next = BRANCH;
      end
      BRANCH: begin
        MA = 2'b01; MB = 2'b10; MJ = 2'b10; OP = 5'b10001; MC = 3'b001; RFLd = 1'b1;
      end
      default: next = FETCH1;
    endcase
  end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed scoreboard bench for control_unit
module tb_control_unit;
  logic CLK = 1'b0, CLR, MOC;
  logic [31:0] ir;
  logic RFLd, IRLd, MARLd, MDRLd, FRLd, RW, MOV, typeData, MD, ME, MG, MH, E;
  logic [3:0] px;
  logic [1:0] MA, MB, MF, MI, MJ;
  logic [2:0] MC, T;
  logic [5:0] S;
  logic [4:0] OP;

  typedef struct packed {
    logic rfld, irld, marld, mdrld, frld, rw, mov, td;
    logic [3:0] px;
    logic [1:0] ma, mb;
    logic [2:0] mc;
    logic md, me;
    logic [1:0] mf;
    logic mg, mh;
    logic [1:0] mi, mj;
    logic e;
    logic [2:0] t;
    logic [5:0] s;
    logic [4:0] op;
  } outs_t;
  typedef struct { outs_t v; string n; } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  outs_t x;

  control_unit dut (
    .CLK(CLK), .CLR(CLR), .MOC(MOC), .ir(ir),
    .RFLd(RFLd), .IRLd(IRLd), .MARLd(MARLd), .MDRLd(MDRLd), .FRLd(FRLd),
    .RW(RW), .MOV(MOV), .typeData(typeData), .px(px),
    .MA(MA), .MB(MB), .MC(MC), .MD(MD), .ME(ME), .MF(MF), .MG(MG), .MH(MH),
    .MI(MI), .MJ(MJ), .E(E), .T(T), .S(S), .OP(OP)
  );

  always #5 CLK = ~CLK;

  function automatic outs_t dflt(input logic [5:0] s, input logic [3:0] p);
    outs_t o;
    o = '0; o.rw = 1'b1; o.t = 3'b100; o.op = 5'b10000; o.s = s; o.px = p;
    return o;
  endfunction

  task automatic go(input logic clr, input logic moc, input logic [31:0] irv);
    @(posedge CLK); #1;
    CLR = clr; MOC = moc; ir = irv;
  endtask

  task automatic push(input string n, input outs_t v);
    exp_t e;
    e.n = n; e.v = v;
    q.push_back(e);
  endtask

  task automatic f1();
    outs_t o;
    o = dflt(6'd1, ir[15:12]); o.me = 1'b1; o.marld = 1'b1;
    push("fetch1", o);
  endtask

  task automatic fetch(input logic [31:0] irv, input int stalls);
    outs_t o;
    go(0, 0, ir);
    o = dflt(6'd2, 4'd15); o.rfld = 1; o.ma = 2'b01; o.mb = 2'b11; o.op = 5'b10001;
    o.mc = 3'b001; o.mov = 1;
    push("fetch2", o);
    for (int i = 0; i < stalls; i++) begin
      go(0, 0, ir);
      o = dflt(6'd3, ir[15:12]); o.mov = 1;
      push("fetch3_wait", o);
    end
    go(0, 1, irv);
    o = dflt(6'd3, irv[15:12]); o.mov = 1; o.irld = 1;
    push("fetch3_moc", o);
    go(0, 0, irv);
    o = dflt(6'd4, irv[15:12]); o.e = 1;
    push("decode", o);
  endtask

  // monitor: compare every presented cycle against the oldest expectation
  always @(negedge CLK) begin
    exp_t e;
    outs_t obs;
    if (q.size() > 0) begin
      e = q.pop_front();
      obs = {RFLd, IRLd, MARLd, MDRLd, FRLd, RW, MOV, typeData, px, MA, MB, MC, MD, ME,
             MF, MG, MH, MI, MJ, E, T, S, OP};
      checks++;
      if (obs !== e.v) begin
        errors++;
        $display("FAIL %s: got %h (S=%0d) want %h (S=%0d)", e.n, obs, obs.s, e.v, e.v.s);
      end
    end
  end

  initial begin
    CLR = 1; MOC = 0; ir = 32'h0;
    go(1, 0, 0); push("reset1", dflt(6'd0, 4'd0));
    go(0, 0, 0); push("reset2", dflt(6'd0, 4'd0));
    go(0, 0, 0); f1();
    fetch(32'h1AFFFFFD, 5);
    go(0, 0, ir);
    x = dflt(6'd14, 4'd15); x.ma = 2'b01; x.mb = 2'b10; x.mj = 2'b10; x.op = 5'b10001;
    x.mc = 3'b001; x.rfld = 1;
    push("b_branch", x);
    go(0, 0, ir); f1();
    fetch(32'hE0912003, 0);
    go(0, 0, ir);
    x = dflt(6'd5, 4'd2); x.rfld = 1; x.frld = 1; x.mf = 2'b01; x.t = 3'b000; x.op = 5'b00100;
    push("adds_dpreg", x);
    go(0, 0, ir); f1();
    fetch(32'hE5912004, 0);
    go(0, 0, ir);
    x = dflt(6'd7, 4'd2); x.mb = 2'b01; x.op = 5'b10001; x.marld = 1;
    push("ldr_addr", x);
    go(0, 0, ir);
    x = dflt(6'd8, 4'd2); x.mov = 1;
    push("ldr_wait", x);
    go(0, 1, ir);
    x.mdrld = 1;
    push("ldr_read", x);
    go(0, 0, ir);
    x = dflt(6'd9, 4'd2); x.ma = 2'b10; x.md = 1; x.rfld = 1;
    push("ldr_wb", x);
    go(0, 0, ir); f1();
    fetch(32'hE4912004, 0);
    go(0, 0, ir);
    x = dflt(6'd7, 4'd2); x.mb = 2'b01; x.marld = 1;
    push("ldrpost_addr", x);
    go(0, 1, ir);
    x = dflt(6'd8, 4'd2); x.mov = 1; x.mdrld = 1;
    push("ldrpost_read", x);
    go(0, 0, ir);
    x = dflt(6'd9, 4'd2); x.ma = 2'b10; x.md = 1; x.rfld = 1;
    push("ldrpost_ldwb", x);
    go(0, 0, ir);
    x = dflt(6'd12, 4'd1); x.mc = 3'b011; x.rfld = 1; x.mb = 2'b01; x.op = 5'b10001;
    push("ldrpost_basewb", x);
    go(0, 0, ir); f1();
    fetch(32'hE3510005, 0);
    go(0, 0, ir);
    x = dflt(6'd6, 4'd0); x.frld = 1; x.mb = 2'b01; x.mj = 2'b01; x.mf = 2'b11; x.op = 5'b01010;
    push("cmp_dpimm", x);
    go(0, 0, ir); f1();
    fetch(32'hEB000000, 0);
    go(0, 0, ir);
    x = dflt(6'd13, 4'd14); x.mi = 2'b01; x.mc = 3'b010; x.rfld = 1;
    push("bl_link", x);
    go(0, 0, ir);
    x = dflt(6'd14, 4'd15); x.ma = 2'b01; x.mb = 2'b10; x.mj = 2'b10; x.op = 5'b10001;
    x.mc = 3'b001; x.rfld = 1;
    push("bl_branch", x);
    go(0, 0, ir); f1();
    fetch(32'hEF000000, 0);
    go(0, 0, ir); f1();
    for (int k = 0; k < 2; k++) begin
      fetch(32'hE5812000, 0);
      go(0, 0, ir);
      x = dflt(6'd7, 4'd2); x.mb = 2'b01; x.op = 5'b10001; x.marld = 1;
      push("str_addr", x);
      go(0, 0, ir);
      x = dflt(6'd10, 4'd2); x.mh = 1; x.mg = 1; x.mdrld = 1;
      push("str_mdr", x);
      go(k == 1, 1, ir);
      x = dflt(6'd11, 4'd2); x.mov = 1; x.rw = 0;
      push("str_write", x);
      go(0, 0, ir);
      if (k == 0) f1();
      else push("str_clr", dflt(6'd0, 4'd2));
    end
    @(negedge CLK); #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
